stream_deframer: RTL and testbench

- Parametrised successor to the fixed two-byte-header deframer.
- Hunts a configurable-length sync header, then reads a runtime big-endian length field, then streams that many packed payload words as unpacked sub-words, then checks a trailing modular-sum checksum.
- Sits between the UART RX byte stream and the pixel/magnitude consumers.
- Reports per-packet status: last-beat marker, ok pulse, checksum-error pulse, length-error pulse.

---
 rtl/stream_deframer.sv | 192 +++++++++++++++++++
 tb/tb_stream_deframer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_deframer.sv
// Stream deframer: hunts a sync header, reads a big-endian length field, unpacks
// that many payload words into LSB-first sub-words, then checks a modular-sum trailer.
module stream_deframer #(
  parameter int UnpackedWidth  = 2,
  parameter int PackedNum      = 4,
  parameter int HeaderLen      = 2,
  parameter logic [HeaderLen*UnpackedWidth*PackedNum-1:0] HeaderPattern = {8'hA5, 8'h5A},
  parameter int MaxPacketElems = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [UnpackedWidth*PackedNum-1:0] data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [UnpackedWidth-1:0] unpacked_o,
  output logic                     last_o,
  output logic                     pkt_ok_o,
  output logic                     crc_err_o,
  output logic                     len_err_o
);

  localparam int PackedWidth = UnpackedWidth * PackedNum;
  localparam int LenWidth    = $clog2(MaxPacketElems + 1);
  localparam int LenWords    = (LenWidth + PackedWidth - 1) / PackedWidth;
  localparam int LenShW      = LenWords * PackedWidth;
  localparam int HdrW        = $clog2(HeaderLen + 1);
  localparam int LenIdxW     = $clog2(LenWords + 1);
  localparam int SubW        = (PackedNum > 1) ? $clog2(PackedNum) : 1;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               rst_sync_q;
  logic                     rst_n;
  logic [HdrW-1:0]          hdr_idx;
  logic [LenIdxW-1:0]       len_idx;
  logic [LenShW-1:0]        len_sh_q;
  logic [LenWidth-1:0]      len_q;
  logic [LenWidth-1:0]      elem_cnt;
  logic [PackedWidth-1:0]   sum_q;
  logic [PackedWidth-1:0]   buf_q;
  logic                     buf_full;
  logic [SubW-1:0]          sub_idx;
  logic                     last_word_q;
  logic                     pkt_ok_q, crc_err_q, len_err_q;

  logic [PackedWidth-1:0]   hdr_word;
  logic [PackedWidth-1:0]   word0;
  logic [LenShW-1:0]        len_full;
  logic                     accept, out_hs, sub_last, hdr_match, hdr_last, len_last;
  logic                     len_zero, len_too_big, final_load;

  // Assertion is immediate; release is aligned to clk_i through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    hdr_word = '0;
    for (int k = 0; k < HeaderLen; k++) begin
      if (hdr_idx == HdrW'(k)) hdr_word = HeaderPattern[(HeaderLen-1-k)*PackedWidth +: PackedWidth];
    end
  end

  assign word0       = HeaderPattern[HeaderLen*PackedWidth-1 -: PackedWidth];
  assign accept      = valid_i && ready_o;
  assign out_hs      = valid_o && ready_i;
  assign sub_last    = (sub_idx == SubW'(PackedNum - 1));
  assign hdr_match   = (data_i == hdr_word);
  assign hdr_last    = (hdr_idx == HdrW'(HeaderLen - 1));
  assign len_last    = (len_idx == LenIdxW'(LenWords - 1));
  assign len_full    = LenShW'({len_sh_q, data_i});
  assign len_zero    = (len_full == '0);
  assign len_too_big = (len_full > LenShW'(MaxPacketElems));
  assign final_load  = ((elem_cnt + LenWidth'(1)) == len_q);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (accept && hdr_match && hdr_last) state_d = LEN;
      LEN: begin
        if (accept && len_last) begin
          if (len_zero)         state_d = CHECK;
          else if (len_too_big) state_d = HUNT;
          else                  state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept && final_load) state_d = CHECK;
      CHECK:   if (accept) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    valid_o    = buf_full;
    unpacked_o = buf_q[UnpackedWidth-1:0];
    last_o     = buf_full && last_word_q && sub_last;
    pkt_ok_o   = pkt_ok_q;
    crc_err_o  = crc_err_q;
    len_err_o  = len_err_q;
    case (state_q)
      HUNT, LEN: ready_o = 1'b1;
      PAYLOAD:   ready_o = !buf_full || (ready_i && sub_last);
      CHECK:     ready_o = !buf_full;
      default:   ready_o = 1'b0;
    endcase
  end

  // A word accepted in the same cycle as the final sub-word handshake reloads the buffer.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx     <= '0;
      len_idx     <= '0;
      len_sh_q    <= '0;
      len_q       <= '0;
      elem_cnt    <= '0;
      sum_q       <= '0;
      buf_q       <= '0;
      buf_full    <= 1'b0;
      sub_idx     <= '0;
      last_word_q <= 1'b0;
      pkt_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      pkt_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;

      if (out_hs) begin
        buf_q <= buf_q >> UnpackedWidth;
        if (sub_last) begin
          buf_full <= 1'b0;
          sub_idx  <= '0;
        end else begin
          sub_idx <= sub_idx + SubW'(1);
        end
      end

      case (state_q)
        HUNT: begin
          len_idx  <= '0;
          len_sh_q <= '0;
          if (accept) begin
            if (hdr_match) hdr_idx <= hdr_last ? '0 : hdr_idx + HdrW'(1);
            else           hdr_idx <= (data_i == word0) ? HdrW'(1) : '0;
          end
        end
        LEN: begin
          if (accept) begin
            len_sh_q <= len_full;
            len_idx  <= len_idx + LenIdxW'(1);
            if (len_last) begin
              len_idx   <= '0;
              len_q     <= len_full[LenWidth-1:0];
              elem_cnt  <= '0;
              sum_q     <= '0;
              len_err_q <= len_too_big;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            buf_q       <= data_i;
            buf_full    <= 1'b1;
            sub_idx     <= '0;
            last_word_q <= final_load;
            sum_q       <= sum_q + data_i;
            elem_cnt    <= elem_cnt + LenWidth'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            pkt_ok_q  <= (data_i == sum_q);
            crc_err_q <= (data_i != sum_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_deframer.sv
// Directed bench for stream_deframer: hand-computed beat lists and status pulse counts.
module tb_stream_deframer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [1:0] unpacked_o;
  logic       last_o;
  logic       pkt_ok_o, crc_err_o, len_err_o;

  int check_count = 0;
  int error_count = 0;
  int ok_cnt, crc_cnt, len_cnt, valid_cnt, stall_err, bp_err;
  bit random_ready = 1'b0;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_data = 2'b00;
  logic [7:0] stim_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  stream_deframer dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .unpacked_o (unpacked_o),
    .last_o     (last_o),
    .pkt_ok_o   (pkt_ok_o),
    .crc_err_o  (crc_err_o),
    .len_err_o  (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change just after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk_i) begin
    if (valid_o && ready_i) obs_q.push_back({last_o, unpacked_o});
    if (valid_o) valid_cnt++;
    if (pkt_ok_o) ok_cnt++;
    if (crc_err_o) crc_cnt++;
    if (len_err_o) len_cnt++;
    if (prev_stall && (!valid_o || unpacked_o != prev_data)) stall_err++;
    if (valid_o && !ready_i && ready_o) bp_err++;
    prev_stall = valid_o && !ready_i;
    prev_data  = unpacked_o;
  end

  always @(posedge clk_i) begin
    if (random_ready) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounters();
    obs_q.delete();
    ok_cnt = 0; crc_cnt = 0; len_cnt = 0;
    valid_cnt = 0; stall_err = 0; bp_err = 0;
  endtask

  task automatic sendWord(input logic [7:0] w);
    int  waited = 0;
    bit  done = 1'b0;
    valid_i = 1'b1;
    data_i  = w;
    while (!done && waited < 200) begin
      @(negedge clk_i);
      if (ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
      waited++;
    end
    valid_i = 1'b0;
    if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus();
    foreach (stim_q[i]) sendWord(stim_q[i]);
    stim_q.delete();
  endtask

  task automatic expectWord(input logic [7:0] w, input bit last_word);
    for (int k = 0; k < 4; k++) exp_q.push_back({last_word && (k == 3), w[2*k +: 2]});
  endtask

  task automatic waitIdle();
    int n = 0;
    while (valid_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic runPacket(input string name, input int eok, input int ecrc, input int elen);
    clearCounters();
    applyStimulus();
    waitIdle();
    checkOutput({name, "_beats"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) checkOutput($sformatf("%s_beat%0d", name, i), obs_q[i], exp_q[i]);
    end
    checkOutput({name, "_ok"}, ok_cnt, eok);
    checkOutput({name, "_crcerr"}, crc_cnt, ecrc);
    checkOutput({name, "_lenerr"}, len_cnt, elen);
    checkOutput({name, "_stall"}, stall_err, 0);
    checkOutput({name, "_bp"}, bp_err, 0);
    if (exp_q.size() == 0) checkOutput({name, "_novalid"}, valid_cnt, 0);
    exp_q.delete();
  endtask

  task automatic loadClean(input logic [7:0] trailer);
    stim_q = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h1B, 8'hE4, trailer};
    expectWord(8'h1B, 1'b0);
    expectWord(8'hE4, 1'b1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_last", last_o, 0);
    checkOutput("rst_pulses", {pkt_ok_o, crc_err_o, len_err_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_ready", ready_o, 1);

    $display("[TB] clean packet");
    loadClean(8'hFF);
    runPacket("clean", 1, 0, 0);

    $display("[TB] resync with garbage");
    stim_q = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h01, 8'hC3, 8'hC3};
    expectWord(8'hC3, 1'b1);
    runPacket("resync", 1, 0, 0);

    $display("[TB] bad checksum");
    loadClean(8'h00);
    runPacket("badsum", 0, 1, 0);

    $display("[TB] length error then valid packet");
    stim_q = '{8'hA5, 8'h5A, 8'h04, 8'h01};
    runPacket("lenerr", 0, 0, 1);
    loadClean(8'hFF);
    runPacket("after_lenerr", 1, 0, 0);

    $display("[TB] zero length");
    stim_q = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    runPacket("zerolen", 1, 0, 0);

    $display("[TB] backpressure");
    random_ready = 1'b1;
    loadClean(8'hFF);
    runPacket("backpressure", 1, 0, 0);
    random_ready = 1'b0;
    @(posedge clk_i);
    #2;
    ready_i = 1'b1;

    $display("[TB] reset mid-payload");
    clearCounters();
    stim_q = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h1B};
    applyStimulus();
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (obs_q.size() < 3 && n < 50);
    checkOutput("midrst_reach_beat3", obs_q.size(), 3);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", valid_o, 0);
    checkOutput("midrst_last", last_o, 0);
    checkOutput("midrst_data", unpacked_o, 0);
    checkOutput("midrst_pulses", {pkt_ok_o, crc_err_o, len_err_o}, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("midrst_ready", ready_o, 1);
    checkOutput("midrst_valid_after", valid_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("midrst_no_status", ok_cnt + crc_cnt + len_cnt, 0);
    loadClean(8'hFF);
    runPacket("after_reset", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
